// File: rtl/hp1349a_bus_tx.sv
// HP1349A display bus transmitter: FIFO-buffered words driven out
// over the low-true LDAV/LRFD four-phase handshake.
module hp1349a_bus_tx #(
    parameter int FIFO_DEPTH     = 16,
    parameter int SETUP_CYCLES   = 4,
    parameter int HOLD_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [14:0]                   in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          clear_err,
    output logic                          BUS_LDAV,
    input  logic                          BUS_LRFD,
    output logic [14:0]                   BUS_DATA,
    output logic                          busy,
    output logic                          timeout,
    output logic [7:0]                    drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(SETUP_CYCLES + HOLD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, STROBE, RELEASE, WAIT_RDY
    } state_t;

    state_t          state, state_nx;
    logic            lrfd_q, lrfd_s;
    logic [14:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     level_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [TW-1:0]   wcnt, wcnt_nx;
    logic            push, pop, fire, drop;

    assign push = in_valid && in_ready;

    // LRFD idles high (not ready) out of reset until the receiver drives it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {lrfd_s, lrfd_q} <= 2'b11;
        else        {lrfd_s, lrfd_q} <= {lrfd_q, BUS_LRFD};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        wcnt_nx  = wcnt;
        pop      = 1'b0;
        fire     = 1'b0;
        drop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (fifo_level != '0 && !lrfd_s) begin
                    pop      = 1'b1;
                    cnt_nx   = CW'(SETUP_CYCLES - 1);
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    wcnt_nx  = '0;
                    state_nx = STROBE;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            STROBE: begin
                if (lrfd_s) begin
                    cnt_nx   = CW'(HOLD_CYCLES - 1);
                    state_nx = RELEASE;
                end else if (wcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    fire     = 1'b1;
                    drop     = 1'b1;
                    cnt_nx   = CW'(HOLD_CYCLES - 1);
                    state_nx = RELEASE;
                end else begin
                    wcnt_nx = wcnt + TW'(1);
                end
            end
            RELEASE: begin
                if (cnt == '0) begin
                    wcnt_nx  = '0;
                    state_nx = WAIT_RDY;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            WAIT_RDY: begin
                if (!lrfd_s) begin
                    state_nx = IDLE;
                end else if (wcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    fire     = 1'b1;
                    state_nx = IDLE;
                end else begin
                    wcnt_nx = wcnt + TW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        level_nx = fifo_level;
        unique case ({push, pop})
            2'b10:   level_nx = fifo_level + (AW+1)'(1);
            2'b01:   level_nx = fifo_level - (AW+1)'(1);
            default: level_nx = fifo_level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    // All outputs are registered from next-state values so they stay glitch-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            wcnt       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            BUS_LDAV   <= 1'b1;
            BUS_DATA   <= '0;
            timeout    <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            cnt        <= cnt_nx;
            wcnt       <= wcnt_nx;
            fifo_level <= level_nx;
            in_ready   <= level_nx != (AW+1)'(FIFO_DEPTH);
            busy       <= (state_nx != IDLE) || (level_nx != '0);
            BUS_LDAV   <= state_nx != STROBE;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr   <= rd_ptr + AW'(1);
                BUS_DATA <= mem[rd_ptr];
            end
            if (fire)           timeout <= 1'b1;
            else if (clear_err) timeout <= 1'b0;
            if (drop) begin
                if (clear_err)              drop_cnt <= 8'd1;
                else if (drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
            end else if (clear_err) begin
                drop_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/hp1349a_bus_tx.md
# hp1349a_bus_tx

Transmitter end of the HP1349A display bus: takes 15-bit display words from on-chip logic, buffers them in a small FIFO and drives them out over the four-phase LDAV/LRFD handshake. It is the source side of the `hp1349a_top` receiver path. It serves two purposes:
- loopback / bench stimulus for the display pipeline;
- an instrument-side emulator on the GPIO header.

All bus signals are low-true, matching the receiver.

## Interface
Parameters:
- FIFO_DEPTH, 16, word buffer depth; power of two, at least 2
- SETUP_CYCLES, 4, cycles BUS_DATA is stable before LDAV falls; at least 1
- HOLD_CYCLES, 2, cycles BUS_DATA stays stable after LDAV rises; at least 1
- TIMEOUT_CYCLES, 65535, max cycles spent waiting on LRFD in any one state

Ports:
- clk  in  1  system clock (clk25 domain)
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  15  display word to send
- in_valid  in  1  in_data is valid
- in_ready  out  1  FIFO can accept; a push happens when in_valid and in_ready are both high
- clear_err  in  1  one-cycle pulse; clears the timeout and drop_cnt
- BUS_LDAV  out  1  data available, low-true; registered
- BUS_LRFD  in  1  receiver ready for data, low-true; asynchronous to clk
- BUS_DATA  out  15  bus data; registered
- busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty
- timeout  out  1  sticky handshake-timeout flag
- drop_cnt  out  8  number of words abandoned on timeout; saturates at 255
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- BUS_LRFD passes through a 2-flop synchronizer to produce lrfd_s. lrfd_s low means the receiver is ready.
- FIFO:
  - push when in_valid and in_ready; in_ready = not full;
  - pop only from IDLE, only when non-empty;
  - a simultaneous push and pop leaves fifo_level unchanged;
  - pointers wrap modulo FIFO_DEPTH; fifo_level counts 0..FIFO_DEPTH.
- FSM states: IDLE, SETUP, STROBE, RELEASE, WAIT_RDY.
  - IDLE:
    - BUS_LDAV=1.
    - If the FIFO is non-empty and lrfd_s=0: pop the head word into the data register, load cnt=SETUP_CYCLES-1, go to SETUP.
    - Otherwise stay in IDLE.
  - SETUP:
    - BUS_LDAV=1; BUS_DATA = the popped word.
    - Decrement cnt; when cnt=0, go to STROBE.
  - STROBE:
    - BUS_LDAV=0.
    - When lrfd_s=1 (receiver has latched the word): load cnt=HOLD_CYCLES-1, go to RELEASE.
  - RELEASE:
    - BUS_LDAV=1; BUS_DATA held.
    - Decrement cnt; when cnt=0, go to WAIT_RDY.
  - WAIT_RDY:
    - BUS_LDAV=1.
    - When lrfd_s=0, go to IDLE.
- Timeout:
  - A wait counter resets on entry to STROBE or WAIT_RDY and increments every cycle spent in those states.
  - When it reaches TIMEOUT_CYCLES: set timeout=1.
    - In STROBE: increment drop_cnt (saturating) and go to RELEASE.
    - In WAIT_RDY: go to IDLE.
  - The FSM never hangs.
- BUS_DATA keeps its last value in IDLE and WAIT_RDY. It changes only on a pop.
- clear_err clears timeout and drop_cnt. If a timeout fires in the same cycle as clear_err, the timeout wins: timeout=1 and drop_cnt=1 or 0 as appropriate.
- Reset (asynchronous, any state, including mid-handshake):
  - BUS_LDAV=1, BUS_DATA=0, state=IDLE, FIFO flushed;
  - fifo_level=0, in_ready=1, busy=0, timeout=0, drop_cnt=0.
  - The word in flight is lost and is not counted as a drop.

## Timing
- Define cycle 0 as the push into an empty FIFO.
  - Cycle 1: fifo_level=1. IDLE sees non-empty; if lrfd_s=0 it pops.
  - Cycle 2: state=SETUP; BUS_DATA = the word; fifo_level=0.
  - Cycle 2+SETUP_CYCLES: BUS_LDAV=0. With default SETUP_CYCLES=4, LDAV falls at cycle 6.
- LRFD to lrfd_s latency is 2 cycles, so a receiver ack (LRFD rising) is reflected as BUS_LDAV rising 3 cycles later.
- Minimum word period is 2 + SETUP_CYCLES + HOLD_CYCLES + 2×(sync latency 2) cycles, with an immediately responsive receiver.
- Back-to-back words: the next pop happens in the first IDLE cycle with lrfd_s=0. There are no bubbles beyond the FSM path.
- Outputs are glitch-free: all are flop outputs.

## Test plan
- Single word: push 0x5A5A while the receiver model acks 4 cycles after LDAV falls.
  - BUS_DATA=0x5A5A from cycle 2.
  - LDAV low at cycle 6.
  - LDAV high 3 cycles after LRFD rises.
  - BUS_DATA held for 2 cycles after that.
- Burst: push 20 words with FIFO_DEPTH=16 and a slow receiver.
  - in_ready drops when fifo_level=16.
  - All 20 words are received in order with no loss.
  - fifo_level never exceeds 16.
- Receiver not ready: hold BUS_LRFD=1, push 3 words.
  - No LDAV activity; fifo_level=3; busy=1.
  - Release LRFD: all 3 words go out in order.
- Timeout: TIMEOUT_CYCLES=100; the receiver never acks.
  - LDAV is low for exactly 100 cycles.
  - timeout=1, drop_cnt=1, the FSM continues with the next word.
  - clear_err returns timeout and drop_cnt to 0.
- Reset mid-STROBE: assert rst_n=0 while LDAV=0 with 5 words queued.
  - BUS_LDAV=1 and BUS_DATA=0 immediately (asynchronously).
  - fifo_level=0, in_ready=1.
  - After release, no spurious LDAV.
- Simultaneous push and pop at fifo_level=1: level stays 1 and the data order is preserved.
